// File: rtl/sample_log_ctrl.sv
// Circular-FIFO controller for the 16x8 sample memory: streams samples in,
// stores them through the memory pins and streams them back out in order.
module sample_log_ctrl #(
  parameter int   AW        = 4,
  parameter logic OVERWRITE = 1'b0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          s_valid,
  input  logic [7:0]    s_data,
  output logic          s_ready,
  output logic          m_valid,
  output logic [7:0]    m_data,
  input  logic          m_ready,
  input  logic          ovf_clr,
  output logic [AW:0]   count,
  output logic          full,
  output logic          empty,
  output logic          overflow,
  output logic [AW-1:0] mem_addr,
  output logic [7:0]    mem_wdata,
  output logic          mem_write,
  output logic          mem_read,
  input  logic [7:0]    mem_rdata
);

  localparam logic [1:0]  IDLE    = 2'd0;
  localparam logic [1:0]  WR      = 2'd1;
  localparam logic [1:0]  RD      = 2'd2;
  localparam logic [1:0]  RD_WAIT = 2'd3;
  localparam logic [AW:0] DEPTH_C = {1'b1, {AW{1'b0}}};

  logic [1:0]    state_r;
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [AW:0]   count_r;
  logic          full_r;
  logic          empty_r;
  logic          ovf_r;
  logic          last_wr_r;
  logic          m_valid_r;
  logic [7:0]    m_data_r;
  logic [AW-1:0] mem_addr_r;
  logic [7:0]    mem_wdata_r;
  logic          mem_write_r;
  logic          mem_read_r;

  logic          read_grant_s;
  logic          s_ready_s;
  logic [AW:0]   cnt_nxt_s;
  logic          ovw_s;

  // Arbitration: after a write the read side gets the next slot, so a busy input cannot starve the output.
  assign read_grant_s = (state_r == IDLE) && !m_valid_r && (count_r != '0) &&
                        (last_wr_r || !s_valid);
  assign s_ready_s    = (state_r == IDLE) && !read_grant_s &&
                        ((count_r < DEPTH_C) || OVERWRITE);

  // Occupancy bookkeeping for the pointer updates of this cycle.
  always_comb begin
    cnt_nxt_s = count_r;
    ovw_s     = 1'b0;
    case (state_r)
      WR: begin
        if (count_r != DEPTH_C) begin
          cnt_nxt_s = count_r + (AW+1)'(1);
        end else begin
          ovw_s = 1'b1;
        end
      end
      RD:      cnt_nxt_s = count_r - (AW+1)'(1);
      default: cnt_nxt_s = count_r;
    endcase
  end

  // Controller state, memory pin drivers and output register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      wr_ptr_r    <= '0;
      rd_ptr_r    <= '0;
      count_r     <= '0;
      full_r      <= 1'b0;
      empty_r     <= 1'b1;
      ovf_r       <= 1'b0;
      last_wr_r   <= 1'b0;
      m_valid_r   <= 1'b0;
      m_data_r    <= 8'h00;
      mem_addr_r  <= '0;
      mem_wdata_r <= 8'h00;
      mem_write_r <= 1'b0;
      mem_read_r  <= 1'b0;
    end else begin
      count_r <= cnt_nxt_s;
      full_r  <= (cnt_nxt_s == DEPTH_C);
      empty_r <= (cnt_nxt_s == '0);
      if (ovw_s) begin
        ovf_r <= 1'b1;
      end else if (ovf_clr) begin
        ovf_r <= 1'b0;
      end
      if (m_valid_r && m_ready) begin
        m_valid_r <= 1'b0;
      end
      case (state_r)
        IDLE: begin
          if (read_grant_s) begin
            state_r    <= RD;
            mem_read_r <= 1'b1;
            mem_addr_r <= rd_ptr_r;
            last_wr_r  <= 1'b0;
          end else if (s_valid && s_ready_s) begin
            state_r     <= WR;
            mem_write_r <= 1'b1;
            mem_addr_r  <= wr_ptr_r;
            mem_wdata_r <= s_data;
            last_wr_r   <= 1'b1;
          end
        end
        WR: begin
          wr_ptr_r    <= wr_ptr_r + AW'(1);
          if (ovw_s) begin
            rd_ptr_r <= rd_ptr_r + AW'(1);
          end
          mem_write_r <= 1'b0;
          state_r     <= IDLE;
        end
        RD: begin
          rd_ptr_r   <= rd_ptr_r + AW'(1);
          mem_read_r <= 1'b0;
          state_r    <= RD_WAIT;
        end
        RD_WAIT: begin
          m_data_r    <= mem_rdata;
          m_valid_r   <= 1'b1;
          mem_read_r  <= 1'b0;
          mem_write_r <= 1'b0;
          state_r     <= IDLE;
        end
        default: begin
          mem_read_r  <= 1'b0;
          mem_write_r <= 1'b0;
          state_r     <= IDLE;
        end
      endcase
    end
  end

  assign s_ready   = s_ready_s;
  assign m_valid   = m_valid_r;
  assign m_data    = m_data_r;
  assign count     = count_r;
  assign full      = full_r;
  assign empty     = empty_r;
  assign overflow  = ovf_r;
  assign mem_addr  = mem_addr_r;
  assign mem_wdata = mem_wdata_r;
  assign mem_write = mem_write_r;
  assign mem_read  = mem_read_r;

endmodule

// File: tb/tb_sample_log_ctrl.sv
// Directed bench for sample_log_ctrl: one stalling and one overwriting
// instance share the stimulus, each with its own 16x8 memory model.
module tb_sample_log_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       s_valid = 1'b0;
  logic [7:0] s_data = 8'h00;
  logic       m_ready = 1'b0;
  logic       ovf_clr = 1'b0;
  logic       sel = 1'b0;

  logic       s_ready0, s_ready1, m_valid0, m_valid1, full0, full1, empty0, empty1;
  logic       ovf0, ovf1, mem_write0, mem_write1, mem_read0, mem_read1;
  logic [7:0] m_data0, m_data1, mem_wdata0, mem_wdata1;
  logic [7:0] mem_rdata0 = 8'h00;
  logic [7:0] mem_rdata1 = 8'h00;
  logic [4:0] count0, count1;
  logic [3:0] mem_addr0, mem_addr1;
  logic [7:0] mem0 [16];
  logic [7:0] mem1 [16];

  int         n_tests = 0;
  int         n_fail = 0;
  int         both_cnt = 0;
  logic [7:0] rx [$];
  logic [7:0] exp_q [$];

  always #5 clk = ~clk;

  sample_log_ctrl #(.AW(4), .OVERWRITE(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready0),
    .m_valid(m_valid0), .m_data(m_data0), .m_ready(m_ready), .ovf_clr(ovf_clr),
    .count(count0), .full(full0), .empty(empty0), .overflow(ovf0),
    .mem_addr(mem_addr0), .mem_wdata(mem_wdata0), .mem_write(mem_write0),
    .mem_read(mem_read0), .mem_rdata(mem_rdata0));

  sample_log_ctrl #(.AW(4), .OVERWRITE(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready1),
    .m_valid(m_valid1), .m_data(m_data1), .m_ready(m_ready), .ovf_clr(ovf_clr),
    .count(count1), .full(full1), .empty(empty1), .overflow(ovf1),
    .mem_addr(mem_addr1), .mem_wdata(mem_wdata1), .mem_write(mem_write1),
    .mem_read(mem_read1), .mem_rdata(mem_rdata1));

  logic       o_s_ready, o_m_valid, o_full, o_empty, o_ovf, o_mem_write, o_mem_read;
  logic [7:0] o_m_data, o_mem_wdata;
  logic [4:0] o_count;
  logic [3:0] o_mem_addr;
  assign o_s_ready   = sel ? s_ready1   : s_ready0;
  assign o_m_valid   = sel ? m_valid1   : m_valid0;
  assign o_m_data    = sel ? m_data1    : m_data0;
  assign o_full      = sel ? full1      : full0;
  assign o_empty     = sel ? empty1     : empty0;
  assign o_ovf       = sel ? ovf1       : ovf0;
  assign o_count     = sel ? count1     : count0;
  assign o_mem_addr  = sel ? mem_addr1  : mem_addr0;
  assign o_mem_wdata = sel ? mem_wdata1 : mem_wdata0;
  assign o_mem_write = sel ? mem_write1 : mem_write0;
  assign o_mem_read  = sel ? mem_read1  : mem_read0;

  // Synchronous memory models; simultaneous read and write zeroes data_out.
  always @(posedge clk) begin
    if (mem_write0) mem0[mem_addr0] <= mem_wdata0;
    if (mem_read0 && mem_write0) mem_rdata0 <= 8'h00;
    else if (mem_read0) mem_rdata0 <= mem0[mem_addr0];
    if (mem_write1) mem1[mem_addr1] <= mem_wdata1;
    if (mem_read1 && mem_write1) mem_rdata1 <= 8'h00;
    else if (mem_read1) mem_rdata1 <= mem1[mem_addr1];
  end

  // Output-side monitor: logs accepted samples and read/write collisions.
  always @(negedge clk) begin
    if (o_m_valid && m_ready) rx.push_back(o_m_data);
    if ((mem_read0 && mem_write0) || (mem_read1 && mem_write1)) both_cnt <= both_cnt + 1;
  end

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; s_valid = 1'b0; m_ready = 1'b0; ovf_clr = 1'b0;
    step(2);
    rst_n = 1'b1;
  endtask

  task automatic push(input logic [7:0] d);
    int n;
    n = 0;
    s_valid = 1'b1;
    s_data  = d;
    @(negedge clk);
    while (!o_s_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    check_eq("push_ready", o_s_ready, 32'd1);
    step(1);
  endtask

  task automatic wait_rx(input int n);
    int k;
    k = 0;
    while (rx.size() < n && k < 400) begin
      @(negedge clk);
      k++;
    end
    check_eq("rx_count", rx.size(), n);
    step(4);
  endtask

  task automatic check_rx(input string tag, input int base);
    for (int i = 0; i < exp_q.size(); i++) begin
      if (base + i < rx.size()) check_eq(tag, rx[base + i], exp_q[i]);
      else check_eq(tag, 32'hFFFF_FFFF, exp_q[i]);
    end
  endtask

  initial begin
    int base;
    int both0;
    int n;

    // reset values
    do_reset();
    @(negedge clk);
    check_eq("rst_count", o_count, 32'd0);
    check_eq("rst_empty", o_empty, 32'd1);
    check_eq("rst_full", o_full, 32'd0);
    check_eq("rst_ovf", o_ovf, 32'd0);
    check_eq("rst_mvalid", o_m_valid, 32'd0);
    check_eq("rst_mdata", o_m_data, 32'd0);
    check_eq("rst_mem_pins", {o_mem_write, o_mem_read, o_mem_addr, o_mem_wdata}, 32'd0);
    check_eq("rst_s_ready", o_s_ready, 32'd1);

    // 1: three samples flow through in order
    sel = 1'b0; do_reset(); m_ready = 1'b1;
    base = rx.size();
    push(8'h11); push(8'h22); push(8'h33);
    s_valid = 1'b0;
    wait_rx(base + 3);
    exp_q = '{8'h11, 8'h22, 8'h33};
    check_rx("t1_data", base);
    @(negedge clk);
    check_eq("t1_count", o_count, 32'd0);
    check_eq("t1_empty", o_empty, 32'd1);

    // 2: stall when full, nothing lost
    sel = 1'b0; do_reset();
    base = rx.size();
    for (int i = 0; i < 17; i++) push(8'(i));
    s_data = 8'h55;
    step(4);
    @(negedge clk);
    check_eq("t2_count", o_count, 32'd16);
    check_eq("t2_full", o_full, 32'd1);
    check_eq("t2_empty", o_empty, 32'd0);
    check_eq("t2_s_ready", o_s_ready, 32'd0);
    check_eq("t2_mvalid", o_m_valid, 32'd1);
    check_eq("t2_mdata", o_m_data, 32'h00);
    s_valid = 1'b0;
    step(1);
    m_ready = 1'b1;
    wait_rx(base + 17);
    exp_q.delete();
    for (int i = 0; i < 17; i++) exp_q.push_back(8'(i));
    check_rx("t2_data", base);
    check_eq("t2_empty_end", o_empty, 32'd1);

    // 3: overwrite oldest when full, sticky overflow
    sel = 1'b1; do_reset();
    base = rx.size();
    for (int i = 0; i < 18; i++) push(8'(i));
    s_valid = 1'b0;
    step(4);
    @(negedge clk);
    check_eq("t3_ovf", o_ovf, 32'd1);
    check_eq("t3_count", o_count, 32'd16);
    check_eq("t3_full", o_full, 32'd1);
    step(1);
    ovf_clr = 1'b1;
    step(1);
    ovf_clr = 1'b0;
    @(negedge clk);
    check_eq("t3_ovf_clr", o_ovf, 32'd0);
    step(1);
    m_ready = 1'b1;
    wait_rx(base + 17);
    exp_q.delete();
    exp_q.push_back(8'h00);
    for (int i = 2; i < 18; i++) exp_q.push_back(8'(i));
    check_rx("t3_data", base);

    // 4: continuous stream with pointer wrap
    sel = 1'b0; do_reset(); m_ready = 1'b1;
    base = rx.size();
    both0 = both_cnt;
    exp_q.delete();
    for (int i = 0; i < 40; i++) begin
      exp_q.push_back(8'(i * 7 + 3));
      push(8'(i * 7 + 3));
    end
    s_valid = 1'b0;
    wait_rx(base + 40);
    check_rx("t4_data", base);
    check_eq("t4_rd_wr_overlap", both_cnt - both0, 32'd0);
    check_eq("t4_empty", o_empty, 32'd1);

    // 5: reset during a read abandons it
    sel = 1'b0; do_reset(); m_ready = 1'b1;
    push(8'h77);
    s_valid = 1'b0;
    n = 0;
    @(negedge clk);
    while (!o_mem_read && n < 20) begin
      @(negedge clk);
      n++;
    end
    check_eq("t5_in_rd", o_mem_read, 32'd1);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    base = rx.size();
    @(negedge clk);
    check_eq("t5_count", o_count, 32'd0);
    check_eq("t5_mvalid", o_m_valid, 32'd0);
    check_eq("t5_empty", o_empty, 32'd1);
    check_eq("t5_mem_pins", {o_mem_write, o_mem_read, o_mem_addr, o_mem_wdata}, 32'd0);
    check_eq("t5_mdata", o_m_data, 32'd0);
    step(6);
    check_eq("t5_no_stale", rx.size(), base);
    push(8'hA5);
    s_valid = 1'b0;
    wait_rx(base + 1);
    exp_q = '{8'hA5};
    check_rx("t5_data", base);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
